sobel_window_ctrl: RTL and testbench

SOBEL_WINDOW_CTRL -- requirements
Module: sobel_window_ctrl

---
 rtl/sobel_window_ctrl_pkg.sv | 16 +
 rtl/sobel_line_buffer.sv | 39 +++
 rtl/sobel_window_ctrl.sv | 136 +++++++++++++
 tb/tb_sobel_window_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_window_ctrl_pkg.sv
// Shared constants and FSM encoding for the Sobel 3x3 window controller.
package sobel_window_ctrl_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_PIC_WIDTH  = 320;
    localparam int DEF_PIC_HEIGHT = 240;
    localparam int COORD_W        = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// Single-port read-first line buffer with a registered read port and the
// pre-write word exposed so two buffers can be chained as a row delay.
module sobel_line_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 320,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic             i_rd,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [WIDTH-1:0] o_old
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    assign o_old   = r_mem[i_addr];
    assign o_rdata = r_rdata;

    // NOTE: the storage array is deliberately left out of reset so it can map onto RAM; only the read register is reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_rd) begin
            r_rdata <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Streams pixels into two line buffers and emits one registered 3-pixel
// column (rows y-2, y-1, y) per accepted pixel once two full rows are stored.
module sobel_window_ctrl
    import sobel_window_ctrl_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PIC_WIDTH  = DEF_PIC_WIDTH,
    parameter int PIC_HEIGHT = DEF_PIC_HEIGHT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WIDTH-1:0]   s_data,
    input  logic               s_sof,
    output logic               col_valid,
    output logic [WIDTH-1:0]   row_top,
    output logic [WIDTH-1:0]   row_mid,
    output logic [WIDTH-1:0]   row_bot,
    output logic [COORD_W-1:0] col_x,
    output logic [COORD_W-1:0] row_y,
    output logic               frame_done,
    output logic               sof_err
);

    localparam int               AW     = $clog2(PIC_WIDTH);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(PIC_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(PIC_HEIGHT - 1);

    state_t               r_state, w_state_nxt;
    logic [COORD_W-1:0]   r_x, r_y, w_x_nxt, w_y_nxt, w_px;
    logic                 w_accept, w_lb_we, w_col_fire, w_sof_err;
    logic [WIDTH-1:0]     w_lb1_old, w_lb1_q, w_lb2_q, w_lb2_unused;
    logic                 r_col_valid, r_sof_err;
    logic [WIDTH-1:0]     r_row_bot;
    logic [COORD_W-1:0]   r_col_x, r_row_y;

    assign s_ready    = (r_state != ST_DONE);
    assign w_accept   = s_valid && s_ready;
    // A start-of-frame pixel is always (0,0), whatever the counters say.
    assign w_px       = s_sof ? '0 : r_x;
    assign w_lb_we    = w_accept && (s_sof || r_state != ST_IDLE);
    assign w_col_fire = w_accept && !s_sof && (r_state == ST_RUN);
    assign w_sof_err  = w_accept && s_sof && (r_state == ST_FILL || r_state == ST_RUN);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        if (r_state == ST_DONE) begin
            w_state_nxt = ST_IDLE;
        end else if (w_accept && s_sof) begin
            w_state_nxt = ST_FILL;
            w_x_nxt     = COORD_W'(1);
            w_y_nxt     = '0;
        end else if (w_accept && r_state != ST_IDLE) begin
            if (r_x == X_LAST) begin
                w_x_nxt = '0;
                w_y_nxt = r_y + COORD_W'(1);
                if (r_state == ST_FILL && r_y == COORD_W'(1)) begin
                    w_state_nxt = ST_RUN;
                end else if (r_state == ST_RUN && r_y == Y_LAST) begin
                    w_state_nxt = ST_DONE;
                    w_y_nxt     = '0;
                end
            end else begin
                w_x_nxt = r_x + COORD_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_valid <= 1'b0;
            r_sof_err   <= 1'b0;
            r_row_bot   <= '0;
            r_col_x     <= '0;
            r_row_y     <= '0;
        end else begin
            r_col_valid <= w_col_fire;
            r_sof_err   <= w_sof_err;
            if (w_col_fire) begin
                r_row_bot <= s_data;
                r_col_x   <= r_x;
                r_row_y   <= r_y;
            end
        end
    end

    // LB1 holds row y-1; its pre-write word cascades into LB2 (row y-2).
    sobel_line_buffer #(.WIDTH(WIDTH), .DEPTH(PIC_WIDTH), .AW(AW)) u_lb1 (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_lb_we),
        .i_rd    (w_col_fire),
        .i_addr  (w_px[AW-1:0]),
        .i_wdata (s_data),
        .o_rdata (w_lb1_q),
        .o_old   (w_lb1_old)
    );

    sobel_line_buffer #(.WIDTH(WIDTH), .DEPTH(PIC_WIDTH), .AW(AW)) u_lb2 (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_lb_we),
        .i_rd    (w_col_fire),
        .i_addr  (w_px[AW-1:0]),
        .i_wdata (w_lb1_old),
        .o_rdata (w_lb2_q),
        .o_old   (w_lb2_unused)
    );

    assign col_valid  = r_col_valid;
    assign row_top    = w_lb2_q;
    assign row_mid    = w_lb1_q;
    assign row_bot    = r_row_bot;
    assign col_x      = r_col_x;
    assign row_y      = r_row_y;
    assign frame_done = (r_state == ST_DONE);
    assign sof_err    = r_sof_err;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl on a 4x4 frame with pixel = 16*y+x.
module tb_sobel_window_ctrl;

    localparam int W  = 8;
    localparam int PW = 4;
    localparam int PH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_sof = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_ready, col_valid, frame_done, sof_err;
    logic [7:0] row_top, row_mid, row_bot;
    logic [8:0] col_x, row_y;

    typedef struct packed {
        logic [7:0] top;
        logic [7:0] mid;
        logic [7:0] bot;
        logic [8:0] x;
        logic [8:0] y;
    } col_t;

    col_t exp_tab [256];
    col_t mon_e;
    int   wr_idx = 0;
    int   rd_idx = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_cols = 0;
    int   n_done = 0;
    int   n_err = 0;
    int   c0, d0, e0;

    sobel_window_ctrl #(.WIDTH(W), .PIC_WIDTH(PW), .PIC_HEIGHT(PH)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_sof      (s_sof),
        .col_valid  (col_valid),
        .row_top    (row_top),
        .row_mid    (row_mid),
        .row_bot    (row_bot),
        .col_x      (col_x),
        .row_y      (row_y),
        .frame_done (frame_done),
        .sof_err    (sof_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [7:0] pix(input int y, input int x);
        return 8'(16 * y + x);
    endfunction

    // Column monitor: compares every emitted column against the expected table.
    always @(negedge clk) begin
        if (col_valid) begin
            n_cols++;
            if (rd_idx >= wr_idx) begin
                check("extra_col", 32'd1, 32'd0);
            end else begin
                mon_e = exp_tab[rd_idx];
                check("row_top", 32'(row_top), 32'(mon_e.top));
                check("row_mid", 32'(row_mid), 32'(mon_e.mid));
                check("row_bot", 32'(row_bot), 32'(mon_e.bot));
                check("col_x",   32'(col_x),   32'(mon_e.x));
                check("row_y",   32'(row_y),   32'(mon_e.y));
                rd_idx++;
            end
        end
        if (frame_done) n_done++;
        if (sof_err)    n_err++;
    end

    task automatic drive(input logic v, input logic sof, input logic [7:0] d, output logic acc);
        @(negedge clk);
        s_valid = v;
        s_sof   = sof;
        s_data  = d;
        acc     = v && s_ready;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, acc);
    endtask

    task automatic send_px(input int y, input int x, input logic sof, input bit stall, output int tries);
        logic acc;
        tries = 0;
        if (stall) drive(1'b0, 1'b0, 8'hee, acc);
        do begin
            drive(1'b1, sof, pix(y, x), acc);
            tries++;
        end while (!acc && tries < 20);
        if (!acc) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else if (y >= 2 && !sof) begin
            exp_tab[wr_idx[7:0]] = '{top: pix(y - 2, x), mid: pix(y - 1, x), bot: pix(y, x),
                                     x: 9'(x), y: 9'(y)};
            wr_idx++;
        end
    endtask

    task automatic send_frame(input bit stall, output int first_tries);
        int t;
        first_tries = 0;
        for (int y = 0; y < PH; y++) begin
            for (int x = 0; x < PW; x++) begin
                send_px(y, x, (y == 0 && x == 0), stall, t);
                if (y == 0 && x == 0) first_tries = t;
            end
        end
    endtask

    task automatic snap();
        c0 = n_cols;
        d0 = n_done;
        e0 = n_err;
    endtask

    task automatic frame_result(input string tag, input int cols, input int dones, input int errs);
        idle(3);
        check({tag, "_cols"},  32'(n_cols - c0), 32'(cols));
        check({tag, "_done"},  32'(n_done - d0), 32'(dones));
        check({tag, "_err"},   32'(n_err - e0),  32'(errs));
        check({tag, "_drain"}, 32'(rd_idx),      32'(wr_idx));
    endtask

    task automatic reset_outputs(input string tag);
        check({tag, "_col_valid"},  32'(col_valid),  32'd0);
        check({tag, "_row_top"},    32'(row_top),    32'd0);
        check({tag, "_row_mid"},    32'(row_mid),    32'd0);
        check({tag, "_row_bot"},    32'(row_bot),    32'd0);
        check({tag, "_col_x"},      32'(col_x),      32'd0);
        check({tag, "_row_y"},      32'(row_y),      32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_sof_err"},    32'(sof_err),    32'd0);
        check({tag, "_s_ready"},    32'(s_ready),    32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  t;
        logic acc;

        // Power-on reset.
        repeat (2) @(negedge clk);
        reset_outputs("por");
        rst = 1'b0;
        idle(2);

        // Continuous frame, including frame_done timing and DONE back-pressure.
        snap();
        send_frame(1'b0, t);
        drive(1'b0, 1'b0, 8'h00, acc);
        check("done_pulse",   32'(frame_done), 32'd1);
        check("done_ready",   32'(s_ready),    32'd0);
        drive(1'b0, 1'b0, 8'h00, acc);
        check("done_cleared", 32'(frame_done), 32'd0);
        check("idle_ready",   32'(s_ready),    32'd1);
        frame_result("cont", 8, 1, 0);

        // Same frame with s_valid toggling every other cycle.
        snap();
        send_frame(1'b1, t);
        frame_result("stall", 8, 1, 0);

        // Pixels without s_sof in IDLE are accepted and dropped.
        snap();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 8'(8'h5a + i), acc);
            check("junk_accepted", 32'(acc), 32'd1);
        end
        send_frame(1'b0, t);
        frame_result("junk", 8, 1, 0);

        // s_sof re-asserted with the controller at (x=2, y=2).
        snap();
        for (int i = 0; i < 2 * PW + 2; i++) send_px(i / PW, i % PW, (i == 0), 1'b0, t);
        send_frame(1'b0, t);
        frame_result("resof", 10, 1, 1);

        // Reset with the controller at (x=3, y=1), then a fresh frame.
        snap();
        for (int i = 0; i < PW + 3; i++) send_px(i / PW, i % PW, (i == 0), 1'b0, t);
        @(negedge clk);
        s_valid = 1'b0;
        rst     = 1'b1;
        #1;
        reset_outputs("mid_rst");
        @(negedge clk);
        check("mid_rst_ready", 32'(s_ready), 32'd1);
        rst = 1'b0;
        send_frame(1'b0, t);
        frame_result("rst", 8, 1, 0);

        // Back-to-back frames: the second s_sof is refused once by DONE.
        snap();
        send_frame(1'b0, t);
        send_frame(1'b0, t);
        check("b2b_refusals", 32'(t - 1), 32'd1);
        frame_result("b2b", 16, 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
